// File: rtl/ttt_game_ctrl.sv
// ---------------------------------------------------------------------------
// ttt_game_ctrl
//
// Sequential tic-tac-toe referee. Accepts one move at a time over a
// valid/ready handshake, rejects illegal moves with a one-cycle pulse,
// evaluates win/tie on the registered board one cycle after each accepted
// move, and keeps saturating per-outcome score counters across games.
//
// Parameters:
//   FIRST_PLAYER  side to move after reset/new_game (0 = X, 1 = O)
//   SCORE_W       width of each saturating score counter
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   new_game    synchronous clear of board/game state (scores kept)
//   move_valid  move request
//   move_pos    cell index 0..8, row-major (bit i of a board = cell i)
//   move_ready  high while a move can be accepted (decoded from state)
//   xboard      cells held by X
//   oboard      cells held by O
//   turn        side to move (0 = X, 1 = O)
//   illegal     one-cycle pulse after a rejected move
//   result      00 playing, 01 X won, 10 O won, 11 tie
//   win_line    OR of all completed line masks of the winner, else 0
//   x_score     games won by X (saturating)
//   o_score     games won by O (saturating)
//   tie_score   tied games (saturating)
// ---------------------------------------------------------------------------
module ttt_game_ctrl #(
  parameter bit FIRST_PLAYER = 1'b0,
  parameter int SCORE_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               new_game,
  input  logic               move_valid,
  input  logic [3:0]         move_pos,
  output logic               move_ready,
  output logic [8:0]         xboard,
  output logic [8:0]         oboard,
  output logic               turn,
  output logic               illegal,
  output logic [1:0]         result,
  output logic [8:0]         win_line,
  output logic [SCORE_W-1:0] x_score,
  output logic [SCORE_W-1:0] o_score,
  output logic [SCORE_W-1:0] tie_score
);

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] RES_PLAYING = 2'b00;
  localparam logic [1:0] RES_X_WIN   = 2'b01;
  localparam logic [1:0] RES_O_WIN   = 2'b10;
  localparam logic [1:0] RES_TIE     = 2'b11;

  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  // The eight winning lines, index 0 at the right-hand end.
  // 0:{0,1,2} 1:{3,4,5} 2:{6,7,8} 3:{0,3,6} 4:{1,4,7} 5:{2,5,8}
  // 6:{0,4,8} 7:{2,4,6}
  localparam logic [7:0][8:0] LINE_MASKS = {
    9'b001010100,
    9'b100010001,
    9'b100100100,
    9'b010010010,
    9'b001001001,
    9'b111000000,
    9'b000111000,
    9'b000000111
  };

  state_t     state_reg;
  logic [3:0] count_reg;

  // ---------------------------------------------------------------------
  // Move decode
  // ---------------------------------------------------------------------
  logic [8:0] cell_mask;
  logic       pos_out_of_range;
  logic       cell_occupied;
  logic       move_legal;

  assign cell_mask        = 9'd1 << move_pos;
  assign pos_out_of_range = (move_pos > 4'd8);
  // cell_mask is zero for positions above 8, so occupancy is only
  // meaningful in combination with the range check.
  assign cell_occupied    = |((xboard | oboard) & cell_mask);
  assign move_legal       = !pos_out_of_range && !cell_occupied;

  // ---------------------------------------------------------------------
  // Win evaluation on the mover's registered board. turn has not yet
  // toggled while in CHECK, so it still names the side that just moved.
  // ---------------------------------------------------------------------
  logic [8:0] mover_board;
  logic [7:0] line_hit;
  logic [8:0] hit_mask [8];
  logic [8:0] win_mask;
  logic       any_win;

  assign mover_board = turn ? oboard : xboard;

  for (genvar gi = 0; gi < 8; gi++) begin : g_lines
    assign line_hit[gi] = ((mover_board & LINE_MASKS[gi]) == LINE_MASKS[gi]);
    assign hit_mask[gi] = line_hit[gi] ? LINE_MASKS[gi] : 9'd0;
  end

  always_comb begin
    win_mask = 9'd0;
    for (int i = 0; i < 8; i++) begin
      win_mask = win_mask | hit_mask[i];
    end
  end

  assign any_win = |line_hit;

  // Only the handshake output is combinational.
  assign move_ready = (state_reg == PLAY);

  // ---------------------------------------------------------------------
  // Game FSM with registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= PLAY;
      count_reg <= 4'd0;
      xboard    <= 9'd0;
      oboard    <= 9'd0;
      turn      <= FIRST_PLAYER;
      illegal   <= 1'b0;
      result    <= RES_PLAYING;
      win_line  <= 9'd0;
      x_score   <= '0;
      o_score   <= '0;
      tie_score <= '0;
    end else if (new_game) begin
      // Clears everything but the scores and overrides any move offered
      // in the same cycle.
      state_reg <= PLAY;
      count_reg <= 4'd0;
      xboard    <= 9'd0;
      oboard    <= 9'd0;
      turn      <= FIRST_PLAYER;
      illegal   <= 1'b0;
      result    <= RES_PLAYING;
      win_line  <= 9'd0;
    end else begin
      // illegal is a pulse: cleared every cycle unless re-raised below.
      illegal <= 1'b0;
      case (state_reg)
        PLAY: begin
          if (move_valid) begin
            if (move_legal) begin
              if (turn) begin
                oboard <= oboard | cell_mask;
              end else begin
                xboard <= xboard | cell_mask;
              end
              count_reg <= count_reg + 4'd1;
              state_reg <= CHECK;
            end else begin
              illegal <= 1'b1;
            end
          end
        end

        CHECK: begin
          // A win is tested before the full-board tie, so a line completed
          // by the ninth move is scored as a win.
          if (any_win) begin
            result   <= turn ? RES_O_WIN : RES_X_WIN;
            win_line <= win_mask;
            if (turn) begin
              if (o_score != SCORE_MAX) o_score <= o_score + SCORE_W'(1);
            end else begin
              if (x_score != SCORE_MAX) x_score <= x_score + SCORE_W'(1);
            end
            state_reg <= DONE;
          end else if (count_reg == 4'd9) begin
            result   <= RES_TIE;
            win_line <= 9'd0;
            if (tie_score != SCORE_MAX) tie_score <= tie_score + SCORE_W'(1);
            state_reg <= DONE;
          end else begin
            turn      <= ~turn;
            state_reg <= PLAY;
          end
        end

        DONE: begin
          // Everything holds until new_game; moves are silently ignored.
        end

        default: begin
          state_reg <= PLAY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ttt_game_ctrl.sv
module tb_ttt_game_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       new_game, move_valid;
  logic [3:0] move_pos;
  logic       move_ready;
  logic [8:0] xboard, oboard, win_line;
  logic       turn, illegal;
  logic [1:0] result;
  logic [7:0] x_score, o_score, tie_score;

  // Second instance: O moves first, 2-bit scores for saturation checks.
  logic       new_game1, move_valid1;
  logic [3:0] move_pos1;
  logic       move_ready1;
  logic [8:0] xboard1, oboard1, win_line1;
  logic       turn1, illegal1;
  logic [1:0] result1;
  logic [1:0] x_score1, o_score1, tie_score1;

  ttt_game_ctrl #(.FIRST_PLAYER(1'b0), .SCORE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .new_game(new_game), .move_valid(move_valid),
    .move_pos(move_pos), .move_ready(move_ready), .xboard(xboard),
    .oboard(oboard), .turn(turn), .illegal(illegal), .result(result),
    .win_line(win_line), .x_score(x_score), .o_score(o_score),
    .tie_score(tie_score)
  );

  ttt_game_ctrl #(.FIRST_PLAYER(1'b1), .SCORE_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .new_game(new_game1), .move_valid(move_valid1),
    .move_pos(move_pos1), .move_ready(move_ready1), .xboard(xboard1),
    .oboard(oboard1), .turn(turn1), .illegal(illegal1), .result(result1),
    .win_line(win_line1), .x_score(x_score1), .o_score(o_score1),
    .tie_score(tie_score1)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       ng;
    logic       mv;
    logic [3:0] pos;
    logic [8:0] xb;
    logic [8:0] ob;
    logic       trn;
    logic       ill;
    logic [1:0] res;
    logic [8:0] wl;
    logic       rdy;
    logic [7:0] xs;
    logic [7:0] os;
    logic [7:0] ts;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic ng, input logic mv, input logic [3:0] pos,
                              input logic [8:0] xb, input logic [8:0] ob,
                              input logic trn, input logic ill, input logic [1:0] res,
                              input logic [8:0] wl, input logic rdy,
                              input logic [7:0] xs, input logic [7:0] os,
                              input logic [7:0] ts);
    vec_t v;
    v.ng = ng; v.mv = mv; v.pos = pos; v.xb = xb; v.ob = ob; v.trn = trn;
    v.ill = ill; v.res = res; v.wl = wl; v.rdy = rdy; v.xs = xs; v.os = os;
    v.ts = ts;
    vecs.push_back(v);
  endfunction

  // One move on dut1: accept edge, then its CHECK edge.
  task automatic move1(input logic [3:0] p);
    @(negedge clk);
    move_valid1 = 1'b1;
    move_pos1   = p;
    @(negedge clk);
    move_valid1 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic new_game1_pulse();
    @(negedge clk);
    new_game1 = 1'b1;
    @(negedge clk);
    new_game1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    new_game = 1'b0; move_valid = 1'b0; move_pos = 4'd0;
    new_game1 = 1'b0; move_valid1 = 1'b0; move_pos1 = 4'd0;

    // ---- reset state (asynchronous: checked before any clock edge) ----
    #2 rst_n = 1'b0;
    #1;
    chk("rst xboard", 32'(xboard), 32'd0);
    chk("rst oboard", 32'(oboard), 32'd0);
    chk("rst turn", 32'(turn), 32'd0);
    chk("rst result", 32'(result), 32'd0);
    chk("rst win_line", 32'(win_line), 32'd0);
    chk("rst illegal", 32'(illegal), 32'd0);
    chk("rst x_score", 32'(x_score), 32'd0);
    chk("rst turn fp1", 32'(turn1), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst move_ready", 32'(move_ready), 32'd1);

    // ---- vector table: each entry is one clock; expectations after the edge ----
    //   ng mv pos  xboard        oboard        trn ill res    win_line      rdy xs os ts
    // X wins the top row
    add(0, 1, 0, 9'b000000001, 9'b000000000, 0, 0, 2'b00, 9'b000000000, 0, 0, 0, 0);
    add(0, 0, 0, 9'b000000001, 9'b000000000, 1, 0, 2'b00, 9'b000000000, 1, 0, 0, 0);
    add(0, 1, 3, 9'b000000001, 9'b000001000, 1, 0, 2'b00, 9'b000000000, 0, 0, 0, 0);
    add(0, 0, 0, 9'b000000001, 9'b000001000, 0, 0, 2'b00, 9'b000000000, 1, 0, 0, 0);
    add(0, 1, 1, 9'b000000011, 9'b000001000, 0, 0, 2'b00, 9'b000000000, 0, 0, 0, 0);
    add(0, 0, 0, 9'b000000011, 9'b000001000, 1, 0, 2'b00, 9'b000000000, 1, 0, 0, 0);
    add(0, 1, 4, 9'b000000011, 9'b000011000, 1, 0, 2'b00, 9'b000000000, 0, 0, 0, 0);
    add(0, 0, 0, 9'b000000011, 9'b000011000, 0, 0, 2'b00, 9'b000000000, 1, 0, 0, 0);
    add(0, 1, 2, 9'b000000111, 9'b000011000, 0, 0, 2'b00, 9'b000000000, 0, 0, 0, 0);
    // move_valid held during CHECK is not taken
    add(0, 1, 5, 9'b000000111, 9'b000011000, 0, 0, 2'b01, 9'b000000111, 0, 1, 0, 0);
    // DONE: move ignored, no illegal pulse
    add(0, 1, 5, 9'b000000111, 9'b000011000, 0, 0, 2'b01, 9'b000000111, 0, 1, 0, 0);
    // new_game from DONE with a simultaneous move
    add(1, 1, 4, 9'b000000000, 9'b000000000, 0, 0, 2'b00, 9'b000000000, 1, 1, 0, 0);
    // illegal moves
    add(0, 1, 4, 9'b000010000, 9'b000000000, 0, 0, 2'b00, 9'b000000000, 0, 1, 0, 0);
    add(0, 0, 0, 9'b000010000, 9'b000000000, 1, 0, 2'b00, 9'b000000000, 1, 1, 0, 0);
    add(0, 1, 4, 9'b000010000, 9'b000000000, 1, 1, 2'b00, 9'b000000000, 1, 1, 0, 0);
    add(0, 0, 0, 9'b000010000, 9'b000000000, 1, 0, 2'b00, 9'b000000000, 1, 1, 0, 0);
    add(0, 1, 9, 9'b000010000, 9'b000000000, 1, 1, 2'b00, 9'b000000000, 1, 1, 0, 0);
    add(0, 0, 0, 9'b000010000, 9'b000000000, 1, 0, 2'b00, 9'b000000000, 1, 1, 0, 0);
    add(0, 1, 0, 9'b000010000, 9'b000000001, 1, 0, 2'b00, 9'b000000000, 0, 1, 0, 0);
    add(0, 1, 8, 9'b000010000, 9'b000000001, 0, 0, 2'b00, 9'b000000000, 1, 1, 0, 0);
    add(1, 0, 0, 9'b000000000, 9'b000000000, 0, 0, 2'b00, 9'b000000000, 1, 1, 0, 0);
    // tie game
    add(0, 1, 0, 9'b000000001, 9'b000000000, 0, 0, 2'b00, 9'b000000000, 0, 1, 0, 0);
    add(0, 0, 0, 9'b000000001, 9'b000000000, 1, 0, 2'b00, 9'b000000000, 1, 1, 0, 0);
    add(0, 1, 1, 9'b000000001, 9'b000000010, 1, 0, 2'b00, 9'b000000000, 0, 1, 0, 0);
    add(0, 0, 0, 9'b000000001, 9'b000000010, 0, 0, 2'b00, 9'b000000000, 1, 1, 0, 0);
    add(0, 1, 2, 9'b000000101, 9'b000000010, 0, 0, 2'b00, 9'b000000000, 0, 1, 0, 0);
    add(0, 0, 0, 9'b000000101, 9'b000000010, 1, 0, 2'b00, 9'b000000000, 1, 1, 0, 0);
    add(0, 1, 4, 9'b000000101, 9'b000010010, 1, 0, 2'b00, 9'b000000000, 0, 1, 0, 0);
    add(0, 0, 0, 9'b000000101, 9'b000010010, 0, 0, 2'b00, 9'b000000000, 1, 1, 0, 0);
    add(0, 1, 3, 9'b000001101, 9'b000010010, 0, 0, 2'b00, 9'b000000000, 0, 1, 0, 0);
    add(0, 0, 0, 9'b000001101, 9'b000010010, 1, 0, 2'b00, 9'b000000000, 1, 1, 0, 0);
    add(0, 1, 5, 9'b000001101, 9'b000110010, 1, 0, 2'b00, 9'b000000000, 0, 1, 0, 0);
    add(0, 0, 0, 9'b000001101, 9'b000110010, 0, 0, 2'b00, 9'b000000000, 1, 1, 0, 0);
    add(0, 1, 7, 9'b010001101, 9'b000110010, 0, 0, 2'b00, 9'b000000000, 0, 1, 0, 0);
    add(0, 0, 0, 9'b010001101, 9'b000110010, 1, 0, 2'b00, 9'b000000000, 1, 1, 0, 0);
    add(0, 1, 6, 9'b010001101, 9'b001110010, 1, 0, 2'b00, 9'b000000000, 0, 1, 0, 0);
    add(0, 0, 0, 9'b010001101, 9'b001110010, 0, 0, 2'b00, 9'b000000000, 1, 1, 0, 0);
    add(0, 1, 8, 9'b110001101, 9'b001110010, 0, 0, 2'b00, 9'b000000000, 0, 1, 0, 0);
    add(0, 0, 0, 9'b110001101, 9'b001110010, 0, 0, 2'b11, 9'b000000000, 0, 1, 0, 1);
    add(1, 0, 0, 9'b000000000, 9'b000000000, 0, 0, 2'b00, 9'b000000000, 1, 1, 0, 1);
    // new_game with a simultaneous move while in PLAY
    add(1, 1, 4, 9'b000000000, 9'b000000000, 0, 0, 2'b00, 9'b000000000, 1, 1, 0, 1);
    // ninth-move win with the diagonal as the only completed line
    add(0, 1, 0, 9'b000000001, 9'b000000000, 0, 0, 2'b00, 9'b000000000, 0, 1, 0, 1);
    add(0, 0, 0, 9'b000000001, 9'b000000000, 1, 0, 2'b00, 9'b000000000, 1, 1, 0, 1);
    add(0, 1, 1, 9'b000000001, 9'b000000010, 1, 0, 2'b00, 9'b000000000, 0, 1, 0, 1);
    add(0, 0, 0, 9'b000000001, 9'b000000010, 0, 0, 2'b00, 9'b000000000, 1, 1, 0, 1);
    add(0, 1, 2, 9'b000000101, 9'b000000010, 0, 0, 2'b00, 9'b000000000, 0, 1, 0, 1);
    add(0, 0, 0, 9'b000000101, 9'b000000010, 1, 0, 2'b00, 9'b000000000, 1, 1, 0, 1);
    add(0, 1, 3, 9'b000000101, 9'b000001010, 1, 0, 2'b00, 9'b000000000, 0, 1, 0, 1);
    add(0, 0, 0, 9'b000000101, 9'b000001010, 0, 0, 2'b00, 9'b000000000, 1, 1, 0, 1);
    add(0, 1, 4, 9'b000010101, 9'b000001010, 0, 0, 2'b00, 9'b000000000, 0, 1, 0, 1);
    add(0, 0, 0, 9'b000010101, 9'b000001010, 1, 0, 2'b00, 9'b000000000, 1, 1, 0, 1);
    add(0, 1, 5, 9'b000010101, 9'b000101010, 1, 0, 2'b00, 9'b000000000, 0, 1, 0, 1);
    add(0, 0, 0, 9'b000010101, 9'b000101010, 0, 0, 2'b00, 9'b000000000, 1, 1, 0, 1);
    add(0, 1, 7, 9'b010010101, 9'b000101010, 0, 0, 2'b00, 9'b000000000, 0, 1, 0, 1);
    add(0, 0, 0, 9'b010010101, 9'b000101010, 1, 0, 2'b00, 9'b000000000, 1, 1, 0, 1);
    add(0, 1, 6, 9'b010010101, 9'b001101010, 1, 0, 2'b00, 9'b000000000, 0, 1, 0, 1);
    add(0, 0, 0, 9'b010010101, 9'b001101010, 0, 0, 2'b00, 9'b000000000, 1, 1, 0, 1);
    add(0, 1, 8, 9'b110010101, 9'b001101010, 0, 0, 2'b00, 9'b000000000, 0, 1, 0, 1);
    add(0, 0, 0, 9'b110010101, 9'b001101010, 0, 0, 2'b01, 9'b100010001, 0, 2, 0, 1);
    add(1, 0, 0, 9'b000000000, 9'b000000000, 0, 0, 2'b00, 9'b000000000, 1, 2, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      new_game   = vecs[i].ng;
      move_valid = vecs[i].mv;
      move_pos   = vecs[i].pos;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d xboard", i), 32'(xboard), 32'(vecs[i].xb));
      chk($sformatf("v%0d oboard", i), 32'(oboard), 32'(vecs[i].ob));
      chk($sformatf("v%0d turn", i), 32'(turn), 32'(vecs[i].trn));
      chk($sformatf("v%0d illegal", i), 32'(illegal), 32'(vecs[i].ill));
      chk($sformatf("v%0d result", i), 32'(result), 32'(vecs[i].res));
      chk($sformatf("v%0d win_line", i), 32'(win_line), 32'(vecs[i].wl));
      chk($sformatf("v%0d move_ready", i), 32'(move_ready), 32'(vecs[i].rdy));
      chk($sformatf("v%0d x_score", i), 32'(x_score), 32'(vecs[i].xs));
      chk($sformatf("v%0d o_score", i), 32'(o_score), 32'(vecs[i].os));
      chk($sformatf("v%0d tie_score", i), 32'(tie_score), 32'(vecs[i].ts));
    end
    @(negedge clk);
    new_game = 1'b0; move_valid = 1'b0; move_pos = 4'd0;

    // ---- asynchronous reset in the middle of CHECK ----
    @(negedge clk);
    move_valid = 1'b1;
    move_pos   = 4'd4;
    @(posedge clk);
    #1;
    move_valid = 1'b0;
    chk("midchk in CHECK", 32'(move_ready), 32'd0);
    chk("midchk xboard set", 32'(xboard), 32'h010);
    #1 rst_n = 1'b0;
    #1;
    chk("midchk xboard", 32'(xboard), 32'd0);
    chk("midchk oboard", 32'(oboard), 32'd0);
    chk("midchk turn", 32'(turn), 32'd0);
    chk("midchk result", 32'(result), 32'd0);
    chk("midchk win_line", 32'(win_line), 32'd0);
    chk("midchk x_score", 32'(x_score), 32'd0);
    chk("midchk tie_score", 32'(tie_score), 32'd0);
    chk("midchk ready", 32'(move_ready), 32'd1);
    chk("midchk turn fp1", 32'(turn1), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post-rst idle xboard", 32'(xboard), 32'd0);
    chk("post-rst ready", 32'(move_ready), 32'd1);

    // ---- O-first instance: O wins four games, 2-bit score saturates at 3 ----
    for (int g = 0; g < 4; g++) begin
      move1(4'd0);
      chk($sformatf("g%0d first mover O", g), 32'(oboard1), 32'h001);
      move1(4'd3);
      move1(4'd1);
      move1(4'd4);
      move1(4'd2);
      chk($sformatf("g%0d result", g), 32'(result1), 32'd2);
      chk($sformatf("g%0d win_line", g), 32'(win_line1), 32'h007);
      chk($sformatf("g%0d xboard", g), 32'(xboard1), 32'h018);
      chk($sformatf("g%0d o_score", g), 32'(o_score1), (g < 3) ? 32'(g + 1) : 32'd3);
      chk($sformatf("g%0d x_score", g), 32'(x_score1), 32'd0);
      new_game1_pulse();
      #1;
      chk($sformatf("g%0d ng turn", g), 32'(turn1), 32'd1);
      chk($sformatf("g%0d ng oboard", g), 32'(oboard1), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
